vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_vga_pattern_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern colour generator driven by the vhsync timing block.
// Produces solid colour, colour bars, checkerboard, ramp and a moving bar, with
// timing and colour registered together for a uniform 1-cycle latency.
// Optional build macro: VGA_PATTERN_BORDER_EN forces a one-pixel white frame border.
module vga_pattern_gen #(
  parameter int   COLOR_W     = 8,
  parameter int   H_ACTIVE    = 640,
  parameter int   V_ACTIVE    = 480,
  parameter int   CHECK_SHIFT = 5,
  parameter int   BOX_W       = 16,
  parameter int   SPEED       = 4,
  parameter logic SYNC_IDLE   = 1'b1
) (
  input  logic                   pixel_clk,
  input  logic                   reset_n,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   display_on,
  input  logic [31:0]            hcounter,
  input  logic [31:0]            vcounter,
  input  logic [2:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  output logic [15:0]            frame_cnt
);

  localparam int BW = H_ACTIVE / 8;

  logic               frame_start_p0;
  logic [2:0]         active_mode;
  logic [31:0]        bar_x;
  logic [31:0]        bar_next;
  logic [32:0]        bar_sum;
  logic [32:0]        bar_end;
  logic [2:0]         bar_col;
  logic [COLOR_W-1:0] r_p0;
  logic [COLOR_W-1:0] g_p0;
  logic [COLOR_W-1:0] b_p0;

  // Colour-bar lookup: returns {r,g,b} on/off flags for the bar under column h.
  function automatic logic [2:0] bar_rgb(input logic [31:0] h);
    logic [31:0] q;
    logic [2:0]  idx;
    q   = h / 32'(BW);
    idx = (q > 32'd7) ? 3'd7 : q[2:0];
    case (idx)
      3'd0:    bar_rgb = 3'b111; // white
      3'd1:    bar_rgb = 3'b110; // yellow
      3'd2:    bar_rgb = 3'b011; // cyan
      3'd3:    bar_rgb = 3'b010; // green
      3'd4:    bar_rgb = 3'b101; // magenta
      3'd5:    bar_rgb = 3'b100; // red
      3'd6:    bar_rgb = 3'b001; // blue
      default: bar_rgb = 3'b000; // black
    endcase
  endfunction

  assign frame_start_p0 = (hcounter == 32'd0) && (vcounter == 32'd0);
  assign bar_sum        = {1'b0, bar_x} + 33'(SPEED);
  assign bar_next       = (bar_sum >= 33'(H_ACTIVE)) ? 32'(bar_sum - 33'(H_ACTIVE))
                                                     : 32'(bar_sum);
  // Bar end kept 33 bits wide so a bar near the top of the range never wraps to 0.
  assign bar_end        = {1'b0, bar_x} + 33'(BOX_W);
  assign bar_col        = bar_rgb(hcounter);

  // Per-frame state: latch the requested mode, count frames and move the bar.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      active_mode <= 3'd0;
      bar_x       <= 32'd0;
      frame_cnt   <= 16'd0;
    end else if (frame_start_p0) begin
      active_mode <= mode;
      bar_x       <= bar_next;
      frame_cnt   <= frame_cnt + 16'd1;
    end
  end

  // Pixel colour for the current position using the mode held this cycle.
  always_comb begin
    r_p0 = '0;
    g_p0 = '0;
    b_p0 = '0;
    if (display_on) begin
      case (active_mode)
        3'd0: {r_p0, g_p0, b_p0} = solid_rgb;
        3'd1: begin
          r_p0 = {COLOR_W{bar_col[2]}};
          g_p0 = {COLOR_W{bar_col[1]}};
          b_p0 = {COLOR_W{bar_col[0]}};
        end
        3'd2: begin
          if (hcounter[CHECK_SHIFT] ^ vcounter[CHECK_SHIFT]) begin
            r_p0 = '1;
            g_p0 = '1;
            b_p0 = '1;
          end
        end
        3'd3: begin
          r_p0 = hcounter[COLOR_W-1:0];
          g_p0 = hcounter[COLOR_W-1:0];
          b_p0 = hcounter[COLOR_W-1:0];
        end
        3'd4: begin
          if (({1'b0, hcounter} >= {1'b0, bar_x}) && ({1'b0, hcounter} < bar_end)) begin
            r_p0 = '1;
            g_p0 = '1;
            b_p0 = '1;
          end
        end
        default: begin
          r_p0 = '0;
          g_p0 = '0;
          b_p0 = '0;
        end
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if ((hcounter == 32'd0) || (hcounter == 32'(H_ACTIVE - 1)) ||
          (vcounter == 32'd0) || (vcounter == 32'(V_ACTIVE - 1))) begin
        r_p0 = '1;
        g_p0 = '1;
        b_p0 = '1;
      end
`endif
    end
  end

  // Output register: timing and colour leave together one cycle after their inputs.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
      de    <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      hsync <= hsync_in;
      vsync <= vsync_in;
      de    <= display_on;
      r     <= r_p0;
      g     <= g_p0;
      b     <= b_p0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed testbench for vga_pattern_gen at default parameters.
module tb_vga_pattern_gen;

`ifdef VGA_PATTERN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic        hsync_in;
  logic        vsync_in;
  logic        display_on;
  logic [31:0] hcounter;
  logic [31:0] vcounter;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int errors  = 0;
  int exp_fcnt = 0;

  vga_pattern_gen dut (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .display_on (display_on),
    .hcounter   (hcounter),
    .vcounter   (vcounter),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .r          (r),
    .g          (g),
    .b          (b),
    .frame_cnt  (frame_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Expected colour with the optional border applied (display_on assumed 1).
  function automatic logic [23:0] bexp(input int h, input int v, input logic [23:0] c);
    if (BORDER && (h == 0 || h == 639 || v == 0 || v == 479)) return 24'hFFFFFF;
    return c;
  endfunction

  // Present one pixel between edges, then settle just after the capturing edge.
  task automatic step(input int h, input int v, input logic on);
    @(negedge pixel_clk);
    hcounter   = h;
    vcounter   = v;
    display_on = on;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    mode      = 3'd0;
    solid_rgb = 24'h123456;
    hsync_in  = 1'b0;
    vsync_in  = 1'b0;
    repeat (3) step(10, 10, 1'b1);
    vectors++;
    if ({r, g, b} !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb got=%h want=%h", {r, g, b}, 24'h0);
    end
    vectors++;
    if ({hsync, vsync, de} !== 3'b110) begin
      errors++;
      $display("FAIL reset_sync got=%b want=%b", {hsync, vsync, de}, 3'b110);
    end
    vectors++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_fcnt got=%0d want=0", frame_cnt);
    end
    reset_n = 1'b1;
    step(10, 10, 1'b1);
    vectors++;
    if ({r, g, b, hsync, vsync, de} !== {24'h123456, 3'b001}) begin
      errors++;
      $display("FAIL first_pixel got=%h/%b want=%h/%b", {r, g, b}, {hsync, vsync, de},
               24'h123456, 3'b001);
    end
  endtask

  task automatic test_sync_delay;
    for (int i = 0; i < 4; i++) begin
      hsync_in = i[1];
      vsync_in = i[0];
      step(20, 20, 1'b1);
      vectors++;
      if ({hsync, vsync} !== i[1:0]) begin
        errors++;
        $display("FAIL sync_delay[%0d] got=%b want=%b", i, {hsync, vsync}, i[1:0]);
      end
    end
    hsync_in = 1'b0;
    vsync_in = 1'b0;
  endtask

  task automatic test_mode_switch;
    int          hs [7] = '{100, 300, 0, 32, 32, 5, 5};
    int          vs [7] = '{200, 400, 0, 0, 32, 5, 32};
    logic [23:0] ex [7] = '{24'h123456, 24'h123456, 24'h123456, 24'hFFFFFF,
                            24'h000000, 24'h000000, 24'hFFFFFF};
    mode = 3'd2;
    for (int i = 0; i < 7; i++) begin
      step(hs[i], vs[i], 1'b1);
      if (hs[i] == 0 && vs[i] == 0) exp_fcnt++;
      vectors++;
      if ({r, g, b} !== bexp(hs[i], vs[i], ex[i])) begin
        errors++;
        $display("FAIL mode_switch(%0d,%0d) got=%h want=%h", hs[i], vs[i], {r, g, b},
                 bexp(hs[i], vs[i], ex[i]));
      end
    end
    vectors++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      errors++;
      $display("FAIL mode_switch_fcnt got=%0d want=%0d", frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_colorbars;
    int          hs [10] = '{0, 80, 160, 240, 320, 400, 479, 480, 560, 639};
    logic [23:0] ex [10] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
                             24'hFF0000, 24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};
    mode = 3'd1;
    // Frame-start pixel still renders the old checker mode: (0,0) is a black square.
    step(0, 0, 1'b1);
    exp_fcnt++;
    vectors++;
    if ({r, g, b} !== bexp(0, 0, 24'h000000)) begin
      errors++;
      $display("FAIL bars_frame_start got=%h want=%h", {r, g, b}, bexp(0, 0, 24'h0));
    end
    for (int i = 0; i < 10; i++) begin
      step(hs[i], 100, 1'b1);
      vectors++;
      if ({r, g, b} !== bexp(hs[i], 100, ex[i])) begin
        errors++;
        $display("FAIL colorbar h=%0d got=%h want=%h", hs[i], {r, g, b},
                 bexp(hs[i], 100, ex[i]));
      end
    end
  endtask

  task automatic test_ramp;
    int          hs [3] = '{32'h1A5, 300, 255};
    logic [23:0] ex [3] = '{24'hA5A5A5, 24'h2C2C2C, 24'hFFFFFF};
    mode = 3'd3;
    step(0, 0, 1'b1);
    exp_fcnt++;
    vectors++;
    if ({r, g, b} !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL ramp_frame_start got=%h want=%h", {r, g, b}, 24'hFFFFFF);
    end
    for (int i = 0; i < 3; i++) begin
      step(hs[i], 100, 1'b1);
      vectors++;
      if ({r, g, b} !== ex[i]) begin
        errors++;
        $display("FAIL ramp h=%0d got=%h want=%h", hs[i], {r, g, b}, ex[i]);
      end
    end
    vectors++;
    if (frame_cnt !== 16'(exp_fcnt)) begin
      errors++;
      $display("FAIL ramp_fcnt got=%0d want=%0d", frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_blanking;
    step(32'h1A5, 100, 1'b0);
    vectors++;
    if ({r, g, b, de} !== 25'h0) begin
      errors++;
      $display("FAIL blank got=%h de=%b want=000000 de=0", {r, g, b}, de);
    end
    step(32'h1A5, 100, 1'b1);
    vectors++;
    if ({r, g, b, de} !== {24'hA5A5A5, 1'b1}) begin
      errors++;
      $display("FAIL unblank got=%h de=%b want=a5a5a5 de=1", {r, g, b}, de);
    end
  endtask

  task automatic test_bar_wrap;
    int          h1 [6] = '{635, 636, 637, 638, 639, 0};
    logic [23:0] e1 [6] = '{24'h0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h0};
    int          h2 [4] = '{0, 15, 16, 636};
    logic [23:0] e2 [4] = '{24'hFFFFFF, 24'hFFFFFF, 24'h0, 24'h0};
    // Mid-frame reset with mode 4 requested: mode must stay 0 until a frame start.
    reset_n   = 1'b0;
    mode      = 3'd4;
    solid_rgb = 24'h123456;
    repeat (2) step(50, 100, 1'b1);
    reset_n = 1'b1;
    step(50, 100, 1'b1);
    exp_fcnt = 0;
    vectors++;
    if ({r, g, b} !== 24'h123456 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_mode got=%h fcnt=%0d want=123456 fcnt=0", {r, g, b}, frame_cnt);
    end
    repeat (159) step(0, 0, 1'b1);
    vectors++;
    if (frame_cnt !== 16'd159) begin
      errors++;
      $display("FAIL bar_fcnt159 got=%0d want=159", frame_cnt);
    end
    for (int i = 0; i < 6; i++) begin
      step(h1[i], 100, 1'b1);
      vectors++;
      if ({r, g, b} !== bexp(h1[i], 100, e1[i])) begin
        errors++;
        $display("FAIL bar636 h=%0d got=%h want=%h", h1[i], {r, g, b}, bexp(h1[i], 100, e1[i]));
      end
    end
    step(0, 0, 1'b1);
    vectors++;
    if (frame_cnt !== 16'd160) begin
      errors++;
      $display("FAIL bar_fcnt160 got=%0d want=160", frame_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step(h2[i], 100, 1'b1);
      vectors++;
      if ({r, g, b} !== bexp(h2[i], 100, e2[i])) begin
        errors++;
        $display("FAIL bar0 h=%0d got=%h want=%h", h2[i], {r, g, b}, bexp(h2[i], 100, e2[i]));
      end
    end
  endtask

  task automatic test_border;
    int hs [5] = '{0, 5, 5, 639, 5};
    int vs [5] = '{5, 5, 479, 5, 0};
    reset_n   = 1'b0;
    mode      = 3'd0;
    solid_rgb = 24'h000000;
    step(5, 5, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(hs[i], vs[i], 1'b1);
      vectors++;
      if ({r, g, b} !== bexp(hs[i], vs[i], 24'h0)) begin
        errors++;
        $display("FAIL border(%0d,%0d) got=%h want=%h", hs[i], vs[i], {r, g, b},
                 bexp(hs[i], vs[i], 24'h0));
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    hsync_in   = 1'b0;
    vsync_in   = 1'b0;
    display_on = 1'b0;
    hcounter   = 32'd0;
    vcounter   = 32'd0;
    mode       = 3'd0;
    solid_rgb  = 24'h0;
    test_reset();
    test_sync_delay();
    test_mode_switch();
    test_colorbars();
    test_ramp();
    test_blanking();
    test_bar_wrap();
    test_border();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
